rotate_frame_ctrl: RTL and testbench
====================================

// Module: rotate_frame_ctrl
// PURPOSE
//  Frame-level sequencer for the rotation pipeline. Accepts the raster pixel stream
//  (Start/H_Valid/H_Jump/24-bit data) and writes each pixel to an external frame
//  buffer at its rotated address. When the frame is complete, it reads the buffer
//  out linearly and regenerates the same stream protocol toward the output stage.
// PARAMETERS
//  W       256                  input image width, pixels
//  H       256                  input image height, pixels
//  ADDR_W  $clog2(W*H)          frame buffer address width
// PORTS
//  Clk_in        in   1       system clock, all logic on posedge
//  Rst_n         in   1       asynchronous reset, active-low
//  Rot_Mode      in   2       0=0deg, 1=90deg CW, 2=180deg, 3=270deg CW; sampled on accepted Start_in
//  Start_in      in   1       first-pixel pulse, qualified by H_Valid_in
//  H_Valid_in    in   1       input pixel valid
//  H_Jump_in     in   1       end-of-row pulse, with H_Valid_in low
//  Bmp_Data      in   24      input pixel RRGGBB
//  Mem_Wr_En     out  1       frame buffer write strobe
//  Mem_Wr_Addr   out  ADDR_W  write address
//  Mem_Wr_Data   out  24      write data
//  Mem_Rd_En     out  1       frame buffer read strobe; data returns exactly 1 cycle later
//  Mem_Rd_Addr   out  ADDR_W  read address
//  Mem_Rd_Data   in   24      read data
//  Start_out     out  1       first output pixel pulse, coincident with H_Valid_out
//  H_Valid_out   out  1       output pixel valid
//  H_Jump_out    out  1       output end-of-row pulse
//  Data_out      out  24      output pixel, equals Mem_Rd_Data while H_Valid_out is high, else 0
//  Busy          out  1       high in any state other than IDLE
//  Frame_Done    out  1       1-cycle pulse after the last output H_Jump_out
//  Err           out  1       sticky protocol error; cleared only by reset or an accepted Start_in in IDLE
// BEHAVIOUR
//  Reset: state=IDLE; all counters 0; every output 0. Rot_Mode register resets to 0.
//  States: IDLE -> WRITE -> READ -> IDLE.
//  IDLE: Start_in&H_Valid_in -> latch Rot_Mode, clear Err, write pixel (r=0,c=0), c=1, go WRITE.
//    Other inputs are ignored.
//  WRITE: row counter r (0..H-1), column counter c (0..W).
//    H_Valid_in & c<W: write the pixel, c++.
//    H_Valid_in & c==W: drop the pixel, set Err.
//    H_Jump_in: if c!=W, set Err. Then c=0, r++.
//    If r==H-1 at the H_Jump_in, go READ on the next cycle.
//    Start_in in WRITE: abort, set Err, restart at r=0,c=0 with this pixel and re-latch Rot_Mode.
//    H_Valid_in & H_Jump_in together: set Err; treat as the pixel only.
//  Write address (registered, same cycle as Mem_Wr_En, 1 cycle after input):
//    mode0: r*W+c
//    mode1: c*H+(H-1-r)
//    mode2: (H-1-r)*W+(W-1-c)
//    mode3: (W-1-c)*H+r
//    Products computed at full width, truncated to ADDR_W; never wraps for legal r,c.
//  READ: output width OW = mode odd ? H : W; output height OH = mode odd ? W : H.
//    Per output row: OW cycles of Mem_Rd_En, address incrementing linearly from 0,
//    then 1 gap cycle with no read. Repeat for OH rows; no backpressure.
//  Output stream is the read sequence delayed by 1 cycle:
//    H_Valid_out follows Mem_Rd_En; H_Jump_out marks the gap cycle;
//    Start_out marks the first read of the frame.
//  Frame_Done fires the cycle after the final H_Jump_out. The block returns to IDLE
//    that same cycle.
//  Input activity during READ is ignored; Start_in during READ sets Err.
//  Async reset mid-frame: immediate return to IDLE, all outputs 0, no partial outputs.
// TESTING
//  W=H=4, mode0, pixels 0..15 -> reads 0..15 in order. 4 valid + 1 jump per row.
//    Start_out with pixel 0; Frame_Done once; Err=0.
//  W=4,H=2, mode1, pixel value = r*4+c -> write addr of (r0,c3)=7, (r1,c0)=0.
//    Output OW=2, OH=4; read stream 4,0,5,1,6,2,7,3.
//  W=H=4, mode2 -> pixel 0 written to addr 15, pixel 15 to addr 0.
//    mode3 -> pixel (r0,c0) written to addr 12.
//  Row with 5 valids -> 5th pixel dropped, Err=1.
//    Next row with 3 valids then H_Jump_in -> Err stays 1.
//  Start_in at row 2 of WRITE -> Err=1; frame restarts; full frame then read out correctly.
//  Rst_n low during READ -> all outputs 0 within the same cycle;
//    next Start_in runs a clean frame with Err=0.

Source files
------------

// File: rtl/rotate_frame_ctrl.sv
// Frame-level rotation sequencer.
// Raster pixels are written to an external frame buffer at their rotated address.
// Once the last row is in, the buffer is read back linearly and re-emitted as a
// Start/H_Valid/H_Jump stream.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for Start_in with H_Valid_in; all other inputs ignored
// S_WRITE | accepting raster rows, writing each pixel at its rotated address
// S_READ  | linear read-out, OW reads then one gap per row, OH rows
module rotate_frame_ctrl #(
    parameter int W      = 256,
    parameter int H      = 256,
    parameter int ADDR_W = $clog2(W*H)
) (
    input  logic              Clk_in,
    input  logic              Rst_n,
    input  logic [1:0]        Rot_Mode,
    input  logic              Start_in,
    input  logic              H_Valid_in,
    input  logic              H_Jump_in,
    input  logic [23:0]       Bmp_Data,
    output logic              Mem_Wr_En,
    output logic [ADDR_W-1:0] Mem_Wr_Addr,
    output logic [23:0]       Mem_Wr_Data,
    output logic              Mem_Rd_En,
    output logic [ADDR_W-1:0] Mem_Rd_Addr,
    input  logic [23:0]       Mem_Rd_Data,
    output logic              Start_out,
    output logic              H_Valid_out,
    output logic              H_Jump_out,
    output logic [23:0]       Data_out,
    output logic              Busy,
    output logic              Frame_Done,
    output logic              Err
);

    localparam int RW   = $clog2(H + 1);
    localparam int CW   = $clog2(W + 1);
    localparam int MAXD = (W > H) ? W : H;
    localparam int DW   = $clog2(MAXD + 1);

    localparam logic [RW-1:0]     ROW_LAST = RW'(H - 1);
    localparam logic [CW-1:0]     COL_END  = CW'(W);
    localparam logic [DW-1:0]     W_D      = DW'(W);
    localparam logic [DW-1:0]     H_D      = DW'(H);
    // Address math is done modulo 2**ADDR_W, which yields the same low bits
    // as a full-width product followed by truncation.
    localparam logic [ADDR_W-1:0] A_W      = ADDR_W'(W);
    localparam logic [ADDR_W-1:0] A_H      = ADDR_W'(H);
    localparam logic [ADDR_W-1:0] A_W1     = ADDR_W'(W - 1);
    localparam logic [ADDR_W-1:0] A_H1     = ADDR_W'(H - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WRITE = 2'd1, S_READ = 2'd2} state_t;

    state_t              r_state, w_nxt_state;
    logic [1:0]          r_mode, w_nxt_mode;
    logic [RW-1:0]       r_row, w_nxt_row;
    logic [CW-1:0]       r_col, w_nxt_col;
    logic                r_err, w_nxt_err;
    logic                r_wr_en, w_nxt_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr, w_nxt_wr_addr;
    logic [23:0]         r_wr_data, w_nxt_wr_data;
    logic [ADDR_W-1:0]   r_rd_addr, w_nxt_rd_addr;
    logic [DW-1:0]       r_rd_col, w_nxt_rd_col;
    logic [DW-1:0]       r_rd_row, w_nxt_rd_row;
    logic                r_rd_fin, w_nxt_rd_fin;
    logic                r_hval_out, r_start_out, r_jump_out, r_done;
    logic                w_nxt_done;

    logic                w_start;
    logic [DW-1:0]       w_ow, w_oh;
    logic                w_rd_en;
    logic [1:0]          w_px_mode;
    logic [ADDR_W-1:0]   w_pr, w_pc, w_px_addr;

    assign w_start = Start_in & H_Valid_in;
    assign w_ow    = r_mode[0] ? H_D : W_D;
    assign w_oh    = r_mode[0] ? W_D : H_D;
    assign w_rd_en = (r_state == S_READ) && !r_rd_fin && (r_rd_col < w_ow);

    // Rotated address of the pixel being accepted; a Start pixel is always (0,0)
    // under the incoming Rot_Mode.
    always_comb begin
        w_px_mode = w_start ? Rot_Mode : r_mode;
        w_pr      = w_start ? '0 : ADDR_W'(r_row);
        w_pc      = w_start ? '0 : ADDR_W'(r_col);
        unique case (w_px_mode)
            2'd0:    w_px_addr = w_pr * A_W + w_pc;
            2'd1:    w_px_addr = w_pc * A_H + (A_H1 - w_pr);
            2'd2:    w_px_addr = (A_H1 - w_pr) * A_W + (A_W1 - w_pc);
            default: w_px_addr = (A_W1 - w_pc) * A_H + w_pr;
        endcase
    end

    // Next-state, counters, write strobe and error flag.
    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_mode    = r_mode;
        w_nxt_row     = r_row;
        w_nxt_col     = r_col;
        w_nxt_err     = r_err;
        w_nxt_wr_en   = 1'b0;
        w_nxt_wr_addr = r_wr_addr;
        w_nxt_wr_data = r_wr_data;
        w_nxt_rd_addr = r_rd_addr;
        w_nxt_rd_col  = r_rd_col;
        w_nxt_rd_row  = r_rd_row;
        w_nxt_rd_fin  = r_rd_fin;
        w_nxt_done    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_nxt_mode    = Rot_Mode;
                    w_nxt_err     = 1'b0;
                    w_nxt_wr_en   = 1'b1;
                    w_nxt_wr_addr = w_px_addr;
                    w_nxt_wr_data = Bmp_Data;
                    w_nxt_row     = '0;
                    w_nxt_col     = CW'(1);
                    w_nxt_state   = S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_start) begin
                    w_nxt_err     = 1'b1;
                    w_nxt_mode    = Rot_Mode;
                    w_nxt_wr_en   = 1'b1;
                    w_nxt_wr_addr = w_px_addr;
                    w_nxt_wr_data = Bmp_Data;
                    w_nxt_row     = '0;
                    w_nxt_col     = CW'(1);
                end else if (H_Valid_in) begin
                    if (H_Jump_in) w_nxt_err = 1'b1;
                    if (r_col < COL_END) begin
                        w_nxt_wr_en   = 1'b1;
                        w_nxt_wr_addr = w_px_addr;
                        w_nxt_wr_data = Bmp_Data;
                        w_nxt_col     = r_col + CW'(1);
                    end else begin
                        w_nxt_err = 1'b1;
                    end
                end else if (H_Jump_in) begin
                    if (r_col != COL_END) w_nxt_err = 1'b1;
                    w_nxt_col = '0;
                    if (r_row == ROW_LAST) begin
                        w_nxt_row   = '0;
                        w_nxt_state = S_READ;
                    end else begin
                        w_nxt_row = r_row + RW'(1);
                    end
                end
            end
            S_READ: begin
                if (w_start) w_nxt_err = 1'b1;
                if (r_rd_fin) begin
                    // Final H_Jump_out is on the wire now; done pulses next cycle.
                    w_nxt_state   = S_IDLE;
                    w_nxt_done    = 1'b1;
                    w_nxt_rd_fin  = 1'b0;
                    w_nxt_rd_addr = '0;
                    w_nxt_rd_col  = '0;
                    w_nxt_rd_row  = '0;
                end else if (r_rd_col < w_ow) begin
                    w_nxt_rd_addr = r_rd_addr + ADDR_W'(1);
                    w_nxt_rd_col  = r_rd_col + DW'(1);
                end else begin
                    w_nxt_rd_col = '0;
                    if (r_rd_row == w_oh - DW'(1)) w_nxt_rd_fin = 1'b1;
                    else                           w_nxt_rd_row = r_rd_row + DW'(1);
                end
            end
            default: w_nxt_state = S_IDLE;
        endcase
    end

    // State and datapath registers; the output stream lags the read sequence by one cycle.
    always_ff @(posedge Clk_in or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state     <= S_IDLE;
            r_mode      <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_err       <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_rd_addr   <= '0;
            r_rd_col    <= '0;
            r_rd_row    <= '0;
            r_rd_fin    <= 1'b0;
            r_hval_out  <= 1'b0;
            r_start_out <= 1'b0;
            r_jump_out  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_mode      <= w_nxt_mode;
            r_row       <= w_nxt_row;
            r_col       <= w_nxt_col;
            r_err       <= w_nxt_err;
            r_wr_en     <= w_nxt_wr_en;
            r_wr_addr   <= w_nxt_wr_addr;
            r_wr_data   <= w_nxt_wr_data;
            r_rd_addr   <= w_nxt_rd_addr;
            r_rd_col    <= w_nxt_rd_col;
            r_rd_row    <= w_nxt_rd_row;
            r_rd_fin    <= w_nxt_rd_fin;
            r_hval_out  <= w_rd_en;
            r_start_out <= w_rd_en && (r_rd_row == '0) && (r_rd_col == '0);
            r_jump_out  <= (r_state == S_READ) && !r_rd_fin && (r_rd_col == w_ow);
            r_done      <= w_nxt_done;
        end
    end

    assign Mem_Wr_En   = r_wr_en;
    assign Mem_Wr_Addr = r_wr_addr;
    assign Mem_Wr_Data = r_wr_data;
    assign Mem_Rd_En   = w_rd_en;
    assign Mem_Rd_Addr = r_rd_addr;
    assign Start_out   = r_start_out;
    assign H_Valid_out = r_hval_out;
    assign H_Jump_out  = r_jump_out;
    assign Data_out    = r_hval_out ? Mem_Rd_Data : 24'd0;
    assign Busy        = (r_state != S_IDLE);
    assign Frame_Done  = r_done;
    assign Err         = r_err;

endmodule

// File: tb/tb_rotate_frame_ctrl.sv
// Bench for rotate_frame_ctrl on a 4x2 image with a behavioural frame buffer
// and a geometric rotation model of the expected output frame.
module tb_rotate_frame_ctrl;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int AW = 3;
    localparam int N  = W * H;

    logic          Clk_in = 1'b0;
    logic          Rst_n;
    logic [1:0]    Rot_Mode;
    logic          Start_in, H_Valid_in, H_Jump_in;
    logic [23:0]   Bmp_Data;
    logic          Mem_Wr_En, Mem_Rd_En;
    logic [AW-1:0] Mem_Wr_Addr, Mem_Rd_Addr;
    logic [23:0]   Mem_Wr_Data, Mem_Rd_Data;
    logic          Start_out, H_Valid_out, H_Jump_out, Busy, Frame_Done, Err;
    logic [23:0]   Data_out;

    rotate_frame_ctrl #(.W(W), .H(H)) dut (
        .Clk_in(Clk_in), .Rst_n(Rst_n), .Rot_Mode(Rot_Mode), .Start_in(Start_in),
        .H_Valid_in(H_Valid_in), .H_Jump_in(H_Jump_in), .Bmp_Data(Bmp_Data),
        .Mem_Wr_En(Mem_Wr_En), .Mem_Wr_Addr(Mem_Wr_Addr), .Mem_Wr_Data(Mem_Wr_Data),
        .Mem_Rd_En(Mem_Rd_En), .Mem_Rd_Addr(Mem_Rd_Addr), .Mem_Rd_Data(Mem_Rd_Data),
        .Start_out(Start_out), .H_Valid_out(H_Valid_out), .H_Jump_out(H_Jump_out),
        .Data_out(Data_out), .Busy(Busy), .Frame_Done(Frame_Done), .Err(Err)
    );

    always #5 Clk_in = ~Clk_in;

    // Frame buffer with one-cycle read latency.
    logic [23:0] mem [N];
    logic [23:0] rd_q;
    always @(posedge Clk_in) begin
        if (Mem_Wr_En) mem[Mem_Wr_Addr] <= Mem_Wr_Data;
        if (Mem_Rd_En) rd_q <= mem[Mem_Rd_Addr];
    end
    assign Mem_Rd_Data = rd_q;

    int n_chk = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Input image and rotation model.
    logic [23:0] img [H][W];

    function automatic void src_of(input int mode, input int i, input int j,
                                   output int sr, output int sc);
        case (mode)
            0:       begin sr = i;         sc = j;         end
            1:       begin sr = H - 1 - j; sc = i;         end
            2:       begin sr = H - 1 - i; sc = W - 1 - j; end
            default: begin sr = j;         sc = W - 1 - i; end
        endcase
    endfunction

    function automatic int out_w(input int mode);
        return (mode % 2 == 1) ? H : W;
    endfunction

    function automatic int out_h(input int mode);
        return (mode % 2 == 1) ? W : H;
    endfunction

    function automatic int exp_addr(input int mode, input int r, input int c);
        int sr, sc;
        for (int i = 0; i < out_h(mode); i++)
            for (int j = 0; j < out_w(mode); j++) begin
                src_of(mode, i, j, sr, sc);
                if (sr == r && sc == c) return i * out_w(mode) + j;
            end
        return -1;
    endfunction

    // Output monitor.
    logic [23:0] out_q[$];
    bit          st_q[$];
    int          rowlen_q[$];
    int          wa_q[$];
    logic [23:0] wd_q[$];
    int row_cnt, done_cnt, nz_err;
    bit prev_jump, done_after_jump, done_busy;

    task automatic clr_mon();
        out_q.delete(); st_q.delete(); rowlen_q.delete(); wa_q.delete(); wd_q.delete();
        row_cnt = 0; done_cnt = 0; nz_err = 0;
        prev_jump = 0; done_after_jump = 0; done_busy = 1;
    endtask

    initial begin
        forever begin
            @(negedge Clk_in);
            if (H_Valid_out) begin
                out_q.push_back(Data_out);
                st_q.push_back(Start_out);
                row_cnt++;
            end else if (Data_out != 24'd0 || Start_out) begin
                nz_err++;
            end
            if (H_Jump_out) begin
                rowlen_q.push_back(row_cnt);
                row_cnt = 0;
            end
            if (Frame_Done) begin
                done_cnt++;
                done_after_jump = prev_jump;
                done_busy = Busy;
            end
            prev_jump = H_Jump_out;
            if (Mem_Wr_En) begin
                wa_q.push_back(int'(Mem_Wr_Addr));
                wd_q.push_back(Mem_Wr_Data);
            end
        end
    end

    task automatic tick();
        @(posedge Clk_in);
        #1;
    endtask

    task automatic idle_in();
        Start_in = 0; H_Valid_in = 0; H_Jump_in = 0; Bmp_Data = '0;
    endtask

    task automatic fill_img(input bit seq);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = seq ? 24'(r * W + c) : 24'($urandom);
    endtask

    task automatic send_row(input int r, input int nval, input bit first, input int mode);
        for (int c = 0; c < nval; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle_in();
                tick();
            end
            Start_in   = first && (c == 0);
            H_Valid_in = 1;
            Bmp_Data   = (c < W) ? img[r][c] : 24'($urandom);
            Rot_Mode   = (first && c == 0) ? 2'(mode) : 2'($urandom);
            tick();
            idle_in();
        end
        H_Jump_in = 1;
        tick();
        idle_in();
    endtask

    task automatic send_frame(input int mode);
        for (int r = 0; r < H; r++) send_row(r, W, r == 0, mode);
    endtask

    task automatic check_frame(input int mode, input bit exp_err, input bit chk_wr);
        int sr, sc, nst, badrow, k;
        logic [23:0] e;
        for (k = 0; k < 200 && done_cnt == 0; k++) begin
            H_Valid_in = 1'($urandom);
            H_Jump_in  = 1'($urandom);
            Bmp_Data   = 24'($urandom);
            tick();
        end
        idle_in();
        tick(); tick();
        check_val("done_cnt", done_cnt, 1);
        check_val("out_len", out_q.size(), N);
        for (int i = 0; i < out_h(mode); i++)
            for (int j = 0; j < out_w(mode); j++) begin
                src_of(mode, i, j, sr, sc);
                e = img[sr][sc];
                k = i * out_w(mode) + j;
                check_val("pix", (k < out_q.size()) ? out_q[k] : 24'hx, e);
            end
        nst = 0;
        foreach (st_q[i]) nst += st_q[i];
        check_val("start_first", (st_q.size() > 0) ? st_q[0] : 1'b0, 1);
        check_val("start_cnt", nst, 1);
        check_val("rows", rowlen_q.size(), out_h(mode));
        badrow = 0;
        foreach (rowlen_q[i]) if (rowlen_q[i] != out_w(mode)) badrow++;
        check_val("row_len_bad", badrow, 0);
        check_val("done_after_jump", done_after_jump, 1);
        check_val("busy_at_done", done_busy, 0);
        check_val("idle_zero", nz_err, 0);
        check_val("err", Err, exp_err);
        check_val("busy_idle", Busy, 0);
        if (chk_wr) begin
            check_val("wr_cnt", wa_q.size(), N);
            for (int p = 0; p < N && p < wa_q.size(); p++) begin
                check_val("wr_addr", wa_q[p], exp_addr(mode, p / W, p % W));
                check_val("wr_data", wd_q[p], img[p / W][p % W]);
            end
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {Mem_Wr_En, Mem_Wr_Addr, Mem_Wr_Data, Mem_Rd_En, Mem_Rd_Addr,
                Start_out, H_Valid_out, H_Jump_out, Busy, Frame_Done, Err, Data_out[20:0]};
    endfunction

    initial begin
        int mode, last_mode, mb, k;
        logic [23:0] keep;
        logic [23:0] ex1 [8];
        ex1 = '{24'd4, 24'd0, 24'd5, 24'd1, 24'd6, 24'd2, 24'd7, 24'd3};
        foreach (mem[i]) mem[i] = '0;
        Rot_Mode = 0;
        idle_in();
        Rst_n = 0;
        clr_mon();
        tick(); tick();
        check_val("rst_outs", all_outs(), 64'd0);
        check_val("rst_data", Data_out, 0);
        Rst_n = 1;
        tick();

        // Non-start activity in IDLE is ignored.
        clr_mon();
        for (int i = 0; i < 10; i++) begin
            H_Valid_in = 1'($urandom); H_Jump_in = 1'($urandom); Bmp_Data = 24'($urandom);
            tick();
        end
        idle_in();
        tick();
        check_val("idle_ignore_wr", wa_q.size(), 0);
        check_val("idle_ignore_busy", Busy, 0);

        // 90 deg CW with pixel = r*4+c.
        clr_mon();
        fill_img(1);
        send_frame(1);
        check_frame(1, 0, 1);
        check_val("m1_wr_r0c3", (wa_q.size() > 3) ? wa_q[3] : -1, 7);
        check_val("m1_wr_r1c0", (wa_q.size() > 4) ? wa_q[4] : -1, 0);
        for (int i = 0; i < 8; i++)
            check_val("m1_stream", (i < out_q.size()) ? out_q[i] : 24'hx, ex1[i]);

        // Random frames across all modes.
        last_mode = 1;
        for (int f = 0; f < 8; f++) begin
            mode = (f < 4) ? f : int'($urandom_range(0, 3));
            clr_mon();
            fill_img(0);
            send_frame(mode);
            check_frame(mode, 0, 1);
            if (mode == 2) begin
                check_val("m2_first", (wa_q.size() > 0) ? wa_q[0] : -1, N - 1);
                check_val("m2_last", (wa_q.size() == N) ? wa_q[N-1] : -1, 0);
            end
            if (mode == 3) check_val("m3_first", (wa_q.size() > 0) ? wa_q[0] : -1, (W - 1) * H);
            last_mode = mode;
        end

        // Over-long row then short row; the missing pixel keeps its old buffer value.
        clr_mon();
        keep = img[1][3];
        fill_img(0);
        img[1][3] = keep;
        send_row(0, W + 1, 1, last_mode);
        check_val("err_long_row", Err, 1);
        send_row(1, W - 1, 0, last_mode);
        check_val("err_sticky", Err, 1);
        check_frame(last_mode, 1, 0);

        // Restart mid-frame with a new mode.
        mode = int'($urandom_range(0, 3));
        mb   = int'($urandom_range(0, 3));
        fill_img(0);
        send_row(0, W, 1, mode);
        clr_mon();
        fill_img(0);
        send_frame(mb);
        check_frame(mb, 1, 1);

        // Start in IDLE clears Err.
        clr_mon();
        fill_img(0);
        mode = int'($urandom_range(0, 3));
        send_frame(mode);
        check_frame(mode, 0, 1);

        // Reset during read-out.
        clr_mon();
        fill_img(0);
        send_frame(2);
        for (k = 0; k < 100 && out_q.size() < 2; k++) tick();
        check_val("reached_read", out_q.size() >= 2, 1);
        Rst_n = 0;
        #1;
        check_val("rst_read_outs", all_outs(), 64'd0);
        check_val("rst_read_data", Data_out, 0);
        tick();
        Rst_n = 1;
        tick();
        clr_mon();
        fill_img(0);
        mode = int'($urandom_range(0, 3));
        send_frame(mode);
        check_frame(mode, 0, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
